sram_seq: RTL and testbench

Request sequencer that sits directly upstream of the SRAM access stage. It accepts a write stream and random-access read requests, issues one-cycle write/read pulses with stable address and data, and waits a fixed number of cycles for the access to finish. It returns read data with a one-cycle valid strobe. Its `sram_*` outputs connect one-to-one to the access stage's `addr`, `i_data`, `bit_Write`, `bit_Read` and `o_data`.

---
 rtl/sram_seq.sv | 201 ++++++++++++++++++++
 tb/tb_sram_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_seq.sv
// sram_seq: request sequencer in front of the SRAM access stage.
// Issues one-cycle write/read pulses and waits fixed cycle counts.
//
// Ports:
//   clock_200mhz, pinReset    clock, async active-low reset
//   wr_start, wr_base         reload write pointer (IDLE only)
//   wr_valid/wr_ready/wr_data write stream handshake
//   rd_valid/rd_ready/rd_addr read request handshake
//   rsp_valid, rsp_data       one-cycle read response
//   sram_addr, sram_wdata     registered address / data to access stage
//   sram_write, sram_read     one-cycle request pulses
//   sram_rdata                data returned by access stage
//   wr_ptr, busy, verify_err  status
//
// Optional feature macro: SRAM_VERIFY_EN (read-back check after writes).

module sram_seq #(
    parameter int WR_CYCLES = 5,
    parameter int RD_CYCLES = 6
) (
    input  logic        clock_200mhz,
    input  logic        pinReset,
    input  logic        wr_start,
    input  logic [19:0] wr_base,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [19:0] rd_addr,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic        sram_write,
    output logic        sram_read,
    input  logic [15:0] sram_rdata,
    output logic [19:0] wr_ptr,
    output logic        busy,
    output logic        verify_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_PULSE,
        WR_WAIT,
        RD_PULSE,
        RD_WAIT,
`ifdef SRAM_VERIFY_EN
        VF_PULSE,
        VF_WAIT,
`endif
        GAP
    } state_t;

    state_t     state;
    state_t     stateNext;
    logic [3:0] count;
    logic [3:0] countNext;
    logic       lastRead;
    logic       rdFire;
    logic       wrFire;

    // State register
    always_ff @(posedge clock_200mhz or negedge pinReset) begin
        if (!pinReset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        countNext = count;
        unique case (state)
            IDLE: begin
                if (rdFire) begin
                    stateNext = RD_PULSE;
                end else if (wrFire) begin
                    stateNext = WR_PULSE;
                end
            end
            WR_PULSE: begin
                countNext = 4'(WR_CYCLES - 1);
                stateNext = WR_WAIT;
            end
            WR_WAIT: begin
                if (count == 4'd0) begin
`ifdef SRAM_VERIFY_EN
                    stateNext = VF_PULSE;
`else
                    stateNext = GAP;
`endif
                end else begin
                    countNext = count - 4'd1;
                end
            end
            RD_PULSE: begin
                countNext = 4'(RD_CYCLES - 1);
                stateNext = RD_WAIT;
            end
            RD_WAIT: begin
                if (count == 4'd0) begin
                    stateNext = GAP;
                end else begin
                    countNext = count - 4'd1;
                end
            end
`ifdef SRAM_VERIFY_EN
            VF_PULSE: begin
                countNext = 4'(RD_CYCLES - 1);
                stateNext = VF_WAIT;
            end
            VF_WAIT: begin
                if (count == 4'd0) begin
                    stateNext = GAP;
                end else begin
                    countNext = count - 4'd1;
                end
            end
`endif
            GAP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output decode; ready terms exclude wr_start so a pointer
    // reload never coincides with a transfer.
    always_comb begin
        rd_ready   = (state == IDLE) & ~wr_start;
        wr_ready   = (state == IDLE) & ~wr_start & ~rd_valid;
        rdFire     = rd_valid & rd_ready;
        wrFire     = wr_valid & wr_ready;
        sram_write = (state == WR_PULSE);
`ifdef SRAM_VERIFY_EN
        sram_read  = (state == RD_PULSE) | (state == VF_PULSE);
`else
        sram_read  = (state == RD_PULSE);
`endif
        busy       = (state != IDLE);
        rsp_valid  = (state == GAP) & lastRead;
    end

    // Datapath: address/data only move on an IDLE transfer, so they
    // stay stable for the whole access.
    always_ff @(posedge clock_200mhz or negedge pinReset) begin
        if (!pinReset) begin
            sram_addr  <= 20'd0;
            sram_wdata <= 16'd0;
            wr_ptr     <= 20'd0;
            rsp_data   <= 16'd0;
            lastRead   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (wr_start) begin
                    wr_ptr <= wr_base;
                end else if (rdFire) begin
                    sram_addr <= rd_addr;
                    lastRead  <= 1'b1;
                end else if (wrFire) begin
                    sram_addr  <= wr_ptr;
                    sram_wdata <= wr_data;
                    wr_ptr     <= wr_ptr + 20'd1;
                    lastRead   <= 1'b0;
                end
            end
            if (state == RD_WAIT && count == 4'd0) begin
                rsp_data <= sram_rdata;
            end
        end
    end

`ifdef SRAM_VERIFY_EN
    logic verifyErr;

    // Sticky until reset or an accepted pointer reload
    always_ff @(posedge clock_200mhz or negedge pinReset) begin
        if (!pinReset) begin
            verifyErr <= 1'b0;
        end else if (state == IDLE && wr_start) begin
            verifyErr <= 1'b0;
        end else if (state == VF_WAIT && count == 4'd0
                     && sram_rdata != sram_wdata) begin
            verifyErr <= 1'b1;
        end
    end

    assign verify_err = verifyErr;
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_seq.sv
// tb_sram_seq: directed table-driven bench for sram_seq.
// Includes a small SRAM model (bit-0 corruption option).
`timescale 1ns/1ps

module tb_sram_seq;

    localparam int WR_CYCLES = 5;
    localparam int RD_CYCLES = 6;
`ifdef SRAM_VERIFY_EN
    localparam int WR_IDLE = 15;
`else
    localparam int WR_IDLE = 8;
`endif
    localparam int RD_IDLE = 9;
    localparam int RSP_K   = 8;

    logic        clock_200mhz = 1'b0;
    logic        pinReset = 1'b0;
    logic        wr_start = 1'b0;
    logic [19:0] wr_base = 20'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = 16'd0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [19:0] rd_addr = 20'd0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_write;
    logic        sram_read;
    logic [15:0] sram_rdata;
    logic [19:0] wr_ptr;
    logic        busy;
    logic        verify_err;

    sram_seq #(
        .WR_CYCLES(WR_CYCLES),
        .RD_CYCLES(RD_CYCLES)
    ) dut (
        .clock_200mhz(clock_200mhz),
        .pinReset(pinReset),
        .wr_start(wr_start),
        .wr_base(wr_base),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_addr(rd_addr),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_write(sram_write),
        .sram_read(sram_read),
        .sram_rdata(sram_rdata),
        .wr_ptr(wr_ptr),
        .busy(busy),
        .verify_err(verify_err)
    );

    always #2.5 clock_200mhz = ~clock_200mhz;

    int cyc = 0;
    always @(posedge clock_200mhz) cyc <= cyc + 1;

    // SRAM model: low 8 address bits select the word
    logic [15:0] mem [0:255];
    logic        corrupt = 1'b0;
    always @(posedge clock_200mhz) begin
        if (sram_write) mem[sram_addr[7:0]] <= sram_wdata;
    end
    assign sram_rdata = mem[sram_addr[7:0]] ^ {15'd0, corrupt};

    int nVec = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef enum logic [1:0] {OP_START, OP_WRITE, OP_READ} op_t;

    typedef struct packed {
        op_t         op;
        logic [19:0] addr;
        logic [15:0] data;
        logic [19:0] expAddr;
        logic [15:0] expRsp;
        logic [19:0] expPtr;
    } vec_t;

    vec_t vecs [12];
    int   prevWrPulse = -1;

    function automatic vec_t mk(op_t op, logic [19:0] a, logic [15:0] d,
                                logic [19:0] ea, logic [15:0] er,
                                logic [19:0] ep);
        vec_t v;
        v.op = op; v.addr = a; v.data = d;
        v.expAddr = ea; v.expRsp = er; v.expPtr = ep;
        return v;
    endfunction

    task automatic runVec(input vec_t v, input int idx);
        int n, t0, pulses, pulseK, rspCnt, rspK, idleK;
        logic [19:0] pAddr, a1;
        logic [15:0] pData, rspVal;
        logic stable, isRd, p;
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.op == OP_START) begin
            wr_start = 1'b1;
            wr_base  = v.addr;
            #1;
            chk({tag, " wr_ready@start"}, wr_ready, 0);
            chk({tag, " rd_ready@start"}, rd_ready, 0);
            @(negedge clock_200mhz);
            wr_start = 1'b0;
            #1;
            chk({tag, " wr_ptr"}, wr_ptr, v.expPtr);
            prevWrPulse = -1;
            return;
        end
        isRd = (v.op == OP_READ);
        if (isRd) begin
            rd_valid = 1'b1; rd_addr = v.addr;
        end else begin
            wr_valid = 1'b1; wr_data = v.data;
        end
        #1;
        n = 0;
        while (!(isRd ? rd_ready : wr_ready) && n < 40) begin
            @(negedge clock_200mhz); #1; n++;
        end
        chk({tag, " accept"}, n < 40, 1);
        t0 = cyc;
        pulses = 0; pulseK = 0; rspCnt = 0; rspK = 0; idleK = 0;
        stable = 1'b1; pAddr = '0; pData = '0; rspVal = '0; a1 = '0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clock_200mhz);
            if (k == 1) begin
                rd_valid = 1'b0; wr_valid = 1'b0; a1 = sram_addr;
            end
            p = isRd ? sram_read : sram_write;
            if (p) begin
                pulses++;
                if (pulseK == 0) begin
                    pulseK = k; pAddr = sram_addr; pData = sram_wdata;
                end
            end
            if (busy && sram_addr !== a1) stable = 1'b0;
            if (rsp_valid) begin
                rspCnt++; rspK = k; rspVal = rsp_data;
            end
            if (!busy) begin
                idleK = k;
                break;
            end
        end
        chk({tag, " pulse_k"}, pulseK, 1);
        chk({tag, " pulses"}, pulses, 1);
        chk({tag, " sram_addr"}, pAddr, v.expAddr);
        chk({tag, " addr_stable"}, stable, 1);
        chk({tag, " wr_ptr"}, wr_ptr, v.expPtr);
        if (isRd) begin
            chk({tag, " rsp_cnt"}, rspCnt, 1);
            chk({tag, " rsp_k"}, rspK, RSP_K);
            chk({tag, " rsp_data"}, rspVal, v.expRsp);
            chk({tag, " rsp_hold"}, rsp_data, v.expRsp);
            chk({tag, " idle_k"}, idleK, RD_IDLE);
            prevWrPulse = -1;
        end else begin
            chk({tag, " sram_wdata"}, pData, v.data);
            chk({tag, " rsp_cnt"}, rspCnt, 0);
            chk({tag, " idle_k"}, idleK, WR_IDLE);
            if (prevWrPulse >= 0)
                chk({tag, " wr_spacing"}, t0 + pulseK - prevWrPulse, WR_IDLE);
            prevWrPulse = t0 + pulseK;
        end
    endtask

    task automatic chkResetVals(input string tag);
        chk({tag, " sram_addr"}, sram_addr, 0);
        chk({tag, " sram_wdata"}, sram_wdata, 0);
        chk({tag, " sram_write"}, sram_write, 0);
        chk({tag, " sram_read"}, sram_read, 0);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " rsp_data"}, rsp_data, 0);
        chk({tag, " wr_ptr"}, wr_ptr, 0);
        chk({tag, " verify_err"}, verify_err, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int rdK, wrK, t0, n, cW, cR, cV;
        logic [19:0] wAddr;
        logic [15:0] rVal;

        vecs[0]  = mk(OP_START, 20'h00010, 16'h0, 20'h0, 16'h0, 20'h00010);
        vecs[1]  = mk(OP_WRITE, 20'h0, 16'hA5A5, 20'h00010, 16'h0, 20'h00011);
        vecs[2]  = mk(OP_WRITE, 20'h0, 16'h1234, 20'h00011, 16'h0, 20'h00012);
        vecs[3]  = mk(OP_WRITE, 20'h0, 16'hFFFF, 20'h00012, 16'h0, 20'h00013);
        vecs[4]  = mk(OP_READ, 20'h00011, 16'h0, 20'h00011, 16'h1234, 20'h00013);
        vecs[5]  = mk(OP_READ, 20'h00010, 16'h0, 20'h00010, 16'hA5A5, 20'h00013);
        vecs[6]  = mk(OP_READ, 20'h00012, 16'h0, 20'h00012, 16'hFFFF, 20'h00013);
        vecs[7]  = mk(OP_START, 20'hFFFFF, 16'h0, 20'h0, 16'h0, 20'hFFFFF);
        vecs[8]  = mk(OP_WRITE, 20'h0, 16'h0BEE, 20'hFFFFF, 16'h0, 20'h00000);
        vecs[9]  = mk(OP_WRITE, 20'h0, 16'h0CAF, 20'h00000, 16'h0, 20'h00001);
        vecs[10] = mk(OP_READ, 20'hFFFFF, 16'h0, 20'hFFFFF, 16'h0BEE, 20'h00001);
        vecs[11] = mk(OP_READ, 20'h00000, 16'h0, 20'h00000, 16'h0CAF, 20'h00001);

        // Reset state
        repeat (3) @(negedge clock_200mhz);
        chkResetVals("reset");
        chk("reset wr_ready", wr_ready, 1);
        chk("reset rd_ready", rd_ready, 1);
        pinReset = 1'b1;
        @(negedge clock_200mhz);

        for (int i = 0; i < 12; i++) runVec(vecs[i], i);

        // Simultaneous read and write: read wins, write 9 cycles later
        rd_valid = 1'b1; rd_addr = 20'h00012;
        wr_valid = 1'b1; wr_data = 16'h5555;
        #1;
        chk("both wr_ready", wr_ready, 0);
        chk("both rd_ready", rd_ready, 1);
        t0 = cyc; rdK = 0; wrK = 0; wAddr = '0; rVal = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock_200mhz);
            if (k == 1) rd_valid = 1'b0;
            if (sram_read && rdK == 0) rdK = k;
            if (rsp_valid) rVal = rsp_data;
            if (sram_write && wrK == 0) begin
                wrK = k; wAddr = sram_addr; wr_valid = 1'b0;
            end
            if (wrK != 0 && !busy) break;
        end
        wr_valid = 1'b0;
        chk("both read_k", rdK, 1);
        chk("both rsp_data", rVal, 16'hFFFF);
        chk("both write_k", wrK, 10);
        chk("both write_addr", wAddr, 20'h00001);
        chk("both wr_ptr", wr_ptr, 20'h00002);

        // Reset during WR_WAIT
        wr_valid = 1'b1; wr_data = 16'h7777;
        #1;
        n = 0;
        while (!wr_ready && n < 40) begin
            @(negedge clock_200mhz); #1; n++;
        end
        chk("rst accept", n < 40, 1);
        @(negedge clock_200mhz);
        wr_valid = 1'b0;
        repeat (2) @(negedge clock_200mhz);
        chk("rst busy_before", busy, 1);
        #1 pinReset = 1'b0;
        #1;
        chkResetVals("async_rst");
        repeat (2) @(negedge clock_200mhz);
        pinReset = 1'b1;
        cW = 0; cR = 0; cV = 0;
        repeat (14) begin
            @(negedge clock_200mhz);
            if (sram_write) cW++;
            if (sram_read) cR++;
            if (rsp_valid) cV++;
        end
        chk("post_rst writes", cW, 0);
        chk("post_rst reads", cR, 0);
        chk("post_rst rsp", cV, 0);
        chk("post_rst busy", busy, 0);

        // Corrupted readback
        corrupt = 1'b1;
        wr_start = 1'b1; wr_base = 20'h00020;
        @(negedge clock_200mhz);
        wr_start = 1'b0;
        wr_valid = 1'b1; wr_data = 16'h0F0F;
        @(negedge clock_200mhz);
        wr_valid = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clock_200mhz); n++;
        end
        chk("vf done", n < 40, 1);
`ifdef SRAM_VERIFY_EN
        chk("vf verify_err set", verify_err, 1);
        wr_start = 1'b1; wr_base = 20'h00030;
        @(negedge clock_200mhz);
        wr_start = 1'b0;
        #1;
        chk("vf verify_err clr", verify_err, 0);
`else
        chk("vf verify_err off", verify_err, 0);
`endif
        corrupt = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
